// File: rtl/blink_rate_ctrl_pkg.sv
// Shared definitions for the LED blink-rate controller: rate limits,
// debounce FSM encoding and the per-rate period helper.
package blink_rate_ctrl_pkg;

   localparam int unsigned RATE_W              = 2;
   localparam int unsigned RATE_MAX            = 3;
   localparam int unsigned DEF_BASE_PERIOD     = 50_000_000;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;

   typedef logic [RATE_W-1:0] rate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARM_HI = 2'd1,
      HIGH   = 2'd2,
      ARM_LO = 2'd3
   } db_state_t;

   // Each rate step halves the period.
   function automatic int unsigned period_of(input int unsigned base, input rate_t r);
      return base >> r;
   endfunction

endpackage

// File: rtl/blink_rate_ctrl_if.sv
// Button/enable inputs and tick/rate outputs of the blink-rate controller.
interface blink_rate_ctrl_if;
   import blink_rate_ctrl_pkg::*;

   logic  btn_up;
   logic  btn_down;
   logic  enable;
   logic  tick;
   rate_t rate_sel;

   modport master (output btn_up, output btn_down, output enable,
                   input  tick,   input  rate_sel);
   modport slave  (input  btn_up, input  btn_down, input  enable,
                   output tick,   output rate_sel);
endinterface

// File: rtl/blink_rate_ctrl_debounce.sv
// Two-flop synchronizer plus debounce FSM for one raw push-button;
// press pulses for one cycle when a high level is accepted.
module button_debounce
   import blink_rate_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned DB_W            = 19
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press,
   output logic level
);

   localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1, sync2;
   db_state_t       state, state_nxt;
   logic [DB_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press     = 1'b0;
      case (state)
         IDLE: begin
            if (sync2) begin
               state_nxt = ARM_HI;
               cnt_nxt   = '0;
            end
         end
         ARM_HI: begin
            if (!sync2) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
               press     = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!sync2) begin
               state_nxt = ARM_LO;
               cnt_nxt   = '0;
            end
         end
         ARM_LO: begin
            if (sync2) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      endcase
   end

   assign level = (state == HIGH) || (state == ARM_LO);

endmodule

// File: rtl/blink_rate_ctrl.sv
// Blink-rate controller: debounced faster/slower buttons select a rate,
// and a down-counter emits a one-cycle tick every BASE_PERIOD >> rate cycles.
module blink_rate_ctrl
   import blink_rate_ctrl_pkg::*;
#(
   parameter int unsigned BASE_PERIOD     = DEF_BASE_PERIOD,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 26,
   parameter int unsigned DB_W            = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   blink_rate_ctrl_if.slave  bus
);

   logic             up_press, down_press;
   logic             up_level, down_level;
   logic             levels_unused;
   rate_t            rate_q, rate_nxt;
   logic             rate_chg;
   logic [CNT_W-1:0] cnt_q;
   logic             tick_q;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_up (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_up),
      .press (up_press),
      .level (up_level)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_down (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (bus.btn_down),
      .press (down_press),
      .level (down_level)
   );

   assign levels_unused = up_level ^ down_level;

   function automatic logic [CNT_W-1:0] reload_of(input rate_t r);
      return CNT_W'(period_of(BASE_PERIOD, r) - 1);
   endfunction

   // Simultaneous presses cancel; saturated presses leave rate (and counter) alone.
   always_comb begin
      rate_nxt = rate_q;
      if (up_press && !down_press && (rate_q != rate_t'(RATE_MAX)))
         rate_nxt = rate_q + 1'b1;
      else if (down_press && !up_press && (rate_q != '0))
         rate_nxt = rate_q - 1'b1;
   end

   assign rate_chg = (rate_nxt != rate_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_q <= '0;
         cnt_q  <= CNT_W'(BASE_PERIOD - 1);
         tick_q <= 1'b0;
      end else begin
         rate_q <= rate_nxt;
         tick_q <= 1'b0;
         // A rate change takes priority and swallows any tick due this cycle.
         if (rate_chg) begin
            cnt_q <= reload_of(rate_nxt);
         end else if (bus.enable) begin
            if (cnt_q == '0) begin
               tick_q <= 1'b1;
               cnt_q  <= reload_of(rate_q);
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

   assign bus.tick     = tick_q;
   assign bus.rate_sel = rate_q;

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Directed bench for blink_rate_ctrl with BASE_PERIOD=16, DEBOUNCE_CYCLES=4.
module tb_blink_rate_ctrl;
   import blink_rate_ctrl_pkg::*;

   localparam int unsigned BP = 16;
   localparam int unsigned DC = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   blink_rate_ctrl_if bus ();

   blink_rate_ctrl #(
      .BASE_PERIOD     (BP),
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (26),
      .DB_W            (19)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit rst;
      bit up;
      bit dn;
      bit en;
      int ncyc;
      int exp_rate;
      int exp_ticks;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      bus.enable   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [11:0] glitch;
      int          nt, dbl, found;
      bit          prev;

      // rst=1 starts the record from a fresh reset; ticks counted over ncyc edges.
      tbl.push_back('{1, 1, 0, 1, 10, 1, 0});
      tbl.push_back('{0, 0, 0, 1, 10, 1, 1});
      tbl.push_back('{0, 1, 1, 1, 10, 1, 1});
      tbl.push_back('{0, 0, 0, 1, 10, 1, 2});
      tbl.push_back('{1, 1, 0, 1, 10, 1, 0});
      tbl.push_back('{0, 0, 0, 1, 10, 1, 1});
      tbl.push_back('{0, 1, 0, 1, 10, 2, 1});
      tbl.push_back('{0, 0, 0, 1, 10, 2, 3});
      tbl.push_back('{0, 1, 0, 1, 10, 3, 2});
      tbl.push_back('{0, 0, 0, 1, 10, 3, 5});
      tbl.push_back('{0, 1, 0, 1, 10, 3, 5});
      tbl.push_back('{0, 0, 0, 1, 10, 3, 5});
      tbl.push_back('{0, 0, 1, 1, 10, 2, 3});
      tbl.push_back('{0, 0, 0, 1, 10, 2, 3});

      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      bus.enable   = 1'b1;
      rst_n        = 1'b0;
      #12;
      check("reset tick", int'(bus.tick), 0);
      check("reset rate", int'(bus.rate_sel), 0);

      // Ticks at rate 0 after reset release.
      do_reset();
      for (int k = 1; k <= 50; k++) begin
         step();
         check($sformatf("r0 tick k=%0d", k), int'(bus.tick), (k % 16 == 0) ? 1 : 0);
      end
      check("r0 rate", int'(bus.rate_sel), 0);

      // Up held 20 cycles: rate change on edge 7, then period 8.
      do_reset();
      bus.btn_up = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         if (k == 21) bus.btn_up = 1'b0;
         step();
         check($sformatf("up rate k=%0d", k), int'(bus.rate_sel), (k >= 7) ? 1 : 0);
         check($sformatf("up tick k=%0d", k), int'(bus.tick), (k == 15 || k == 23) ? 1 : 0);
      end

      // Bouncy press never stays high long enough.
      do_reset();
      glitch = 12'b0000_0111_0111;
      for (int k = 0; k < 12; k++) begin
         bus.btn_up = glitch[k];
         step();
         check($sformatf("glitch rate k=%0d", k), int'(bus.rate_sel), 0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         bus.btn_up   = tbl[i].up;
         bus.btn_down = tbl[i].dn;
         bus.enable   = tbl[i].en;
         nt   = 0;
         dbl  = 0;
         prev = 1'b0;
         for (int c = 0; c < tbl[i].ncyc; c++) begin
            step();
            if (bus.tick) begin
               nt++;
               if (prev) dbl++;
            end
            prev = bus.tick;
         end
         check($sformatf("vec%0d rate", i), int'(bus.rate_sel), tbl[i].exp_rate);
         check($sformatf("vec%0d ticks", i), nt, tbl[i].exp_ticks);
         check($sformatf("vec%0d double tick", i), dbl, 0);
      end
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;

      // Enable dropped with counter at 5, held off 30 cycles.
      do_reset();
      for (int k = 1; k <= 10; k++) step();
      bus.enable = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         step();
         check($sformatf("hold tick k=%0d", k), int'(bus.tick), 0);
      end
      bus.enable = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         step();
         check($sformatf("resume tick j=%0d", j), int'(bus.tick), (j == 6) ? 1 : 0);
      end

      // Async reset at rate 2 while tick is high.
      do_reset();
      for (int p = 0; p < 2; p++) begin
         bus.btn_up = 1'b1;
         repeat (10) step();
         bus.btn_up = 1'b0;
         repeat (10) step();
      end
      check("pre-reset rate", int'(bus.rate_sel), 2);
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         step();
         if (bus.tick) found = 1;
      end
      check("tick seen before async reset", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset tick", int'(bus.tick), 0);
      check("async reset rate", int'(bus.rate_sel), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         check($sformatf("post-reset tick k=%0d", k), int'(bus.tick), (k == 16) ? 1 : 0);
      end
      check("post-reset rate", int'(bus.rate_sel), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blink_rate_ctrl.md
Name: blink_rate_ctrl

Overview:
- Upstream timing stage for the LED blinker on the Spartan-3E starter board.
- Debounces two push-buttons (faster/slower) and keeps a 2-bit blink-rate selection.
- Emits a one-cycle `tick` strobe at the selected period; the downstream LED stage toggles its pin on each `tick`.

Parameters:
- BASE_PERIOD, 50_000_000: cycles between ticks at rate 0 (1 s at 50 MHz). Legal range 16 to 2^26; must be divisible by 8.
- DEBOUNCE_CYCLES, 500_000: consecutive stable synchronized samples needed to accept a button level change (10 ms). Minimum 2.
- CNT_W, 26: width of the tick counter.
- DB_W, 19: width of each debounce counter.

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous, active-low reset
- btn_up  input  1  raw, asynchronous button; press selects a faster rate
- btn_down  input  1  raw, asynchronous button; press selects a slower rate
- enable  input  1  tick generation enable, synchronous to clk
- tick  output  1  registered one-cycle strobe at the selected period
- rate_sel  output  2  current rate index; 0 is slowest, 3 is fastest

Behaviour:
- Reset (async assert, sync-safe deassert inside clock domain):
  - tick=0, rate_sel=0, counter=BASE_PERIOD-1.
  - Synchronizers, debounce counters and stable levels all 0.
  - Reset mid-debounce or mid-period discards all progress.
- Synchronization: each button passes through a 2-flop synchronizer; only the second flop is used.
- Debounce (per button, FSM with states IDLE, ARM_HI, HIGH, ARM_LO):
  - IDLE → ARM_HI when the synced input is 1.
  - ARM_HI counts cycles while the input is 1. It returns to IDLE when the input is 0.
  - ARM_HI → HIGH when the count reaches DEBOUNCE_CYCLES-1 and the input is still 1. On this transition `press` pulses high for exactly one cycle.
  - HIGH → ARM_LO and ARM_LO → IDLE behave symmetrically. No pulse on release.
  - The count clears on every state change.
- Latency: from the first clk edge sampling a raw button high (held stable), `rate_sel` changes on edge DEBOUNCE_CYCLES+3.
- Rate update:
  - Up press alone: rate_sel += 1, saturating at 3.
  - Down press alone: rate_sel -= 1, saturating at 0.
  - Both presses in the same cycle: no change.
  - A press at saturation: no change and no counter reload.
- Period: PERIOD(r) = BASE_PERIOD >> r.
- Tick counter:
  - Decrements each cycle while enable=1.
  - At 0 it asserts tick for the next cycle and reloads PERIOD(rate_sel)-1, so ticks are spaced exactly PERIOD cycles apart.
  - While enable=0 the counter holds and tick=0. Re-enable resumes from the held value.
  - When rate_sel changes, the counter reloads PERIOD(new)-1 in the same cycle. No tick is emitted for that cycle, even if the counter was 0 at the time.
  - Wrap-around below 0 never occurs.
- The first tick after reset with enable=1 appears BASE_PERIOD cycles after the first enabled edge.
- tick is never high for 2 consecutive cycles when PERIOD ≥ 2.

Decomposition:
- Shared header blink_defs.vh holds:
  - RATE_W=2, RATE_MAX=3.
  - Debounce FSM state encodings: IDLE=2'd0, ARM_HI=2'd1, HIGH=2'd2, ARM_LO=2'd3.
  - Default BASE_PERIOD and DEBOUNCE_CYCLES.
- Sub-module `button_debounce` (ports clk, rst_n, raw, press, level) contains the synchronizer and FSM. It is instantiated twice.
- Rate register and tick counter stay in the top module.

Test Plan (BASE_PERIOD=16, DEBOUNCE_CYCLES=4 unless stated):
- Reset with enable=1 and no buttons → rate_sel=0; tick pulses at cycles 16, 32, 48 after release, each exactly 1 cycle wide.
- btn_up held high 20 cycles → rate_sel becomes 1 on edge 7 after first sampling, and stays 1. Tick spacing becomes 8 cycles, with the first post-change tick 8 cycles after the change.
- Glitch test: btn_up high for 3 cycles, low 1, high 3 → no rate change. Three presses of 10 cycles each, separated by 10-cycle lows → rate_sel 0→1→2→3. A fourth press → stays 3, tick spacing stays 2.
- btn_up and btn_down raised on the same edge and held 10 cycles → both debounce simultaneously, rate_sel unchanged at its prior value, no counter reload.
- enable dropped at counter=5 for 30 cycles → tick stays 0 and counter holds 5. After re-enable, the tick appears 6 cycles later.
- rst_n asserted asynchronously mid-period (between clock edges) with rate_sel=2 → tick=0 and rate_sel=0 immediately, without waiting for an edge. After release, the first tick comes 16 cycles later.
